// File: rtl/rv_conv_accumulator_if.sv
// Adder-tree input and writeback output bundle for rv_conv_accumulator.
// Output handshake: a beat moves on a clock edge where out_valid && out_ready;
// out_valid never waits for out_ready, and out_data is held until that beat.
interface rv_conv_accumulator_if #(
    parameter int DATAW = 8,
    parameter int ACCW  = 16,
    parameter int CNTW  = 8
);
    logic             in_valid;
    logic [DATAW-1:0] in_data;
    logic [CNTW-1:0]  cfg_terms;
    logic             clear;
    logic             out_valid;
    logic [ACCW-1:0]  out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, cfg_terms, clear, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, cfg_terms, clear, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/rv_conv_accumulator.sv
// Accumulates groups of adder-tree sums into signed results, buffered in a FWFT FIFO.
// Define RV_ACC_SAT_EN to saturate each accumulation step instead of wrapping.
module rv_conv_accumulator #(
    parameter int DATAW = 8,
    parameter int ACCW  = 16,
    parameter int CNTW  = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    rv_conv_accumulator_if.slave   bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};

    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] addend;
    logic [ACCW-1:0] base;
    logic [ACCW-1:0] sum;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] t_lat;
    logic [CNTW-1:0] t_eff;
    logic            accept;
    logic            last;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [ACCW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // clear has priority over a same-cycle input
    assign accept = bus.in_valid && !bus.clear;

    always_comb begin
        addend = {ACCW{bus.in_data[DATAW-1]}};
        addend[DATAW-1:0] = bus.in_data;
    end

    // The group length is sampled only on its first term; later cfg changes are ignored.
    always_comb begin
        t_eff = t_lat;
        if (count == '0) begin
            t_eff = (bus.cfg_terms == '0) ? CNTW'(1) : bus.cfg_terms;
        end
    end

    assign last = (count == t_eff - CNTW'(1));
    assign base = (count == '0) ? '0 : acc;

`ifdef RV_ACC_SAT_EN
    logic [ACCW:0] wide;
    always_comb begin
        wide = {base[ACCW-1], base} + {addend[ACCW-1], addend};
        sum  = wide[ACCW-1:0];
        if (wide[ACCW] != wide[ACCW-1]) begin
            sum = wide[ACCW] ? SMIN : SMAX;
        end
    end
`else
    always_comb begin
        sum = base + addend;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
            t_lat <= CNTW'(1);
        end else if (bus.clear) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            if (count == '0) t_lat <= t_eff;
            if (last) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= sum;
                count <= count + CNTW'(1);
            end
        end
    end

    assign busy = (count != '0);

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign empty    = (fifo_count == '0);
    assign full     = (fifo_count == (AW + 1)'(DEPTH));
    assign pop      = !empty && bus.out_ready;
    assign push_req = accept && last;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_rv_conv_accumulator.sv
// Self-checking bench for rv_conv_accumulator (ACCW=10 so wrap/saturation is reachable).
module tb_rv_conv_accumulator;
  localparam int DATAW = 8;
  localparam int ACCW  = 10;
  localparam int CNTW  = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic [$clog2(DEPTH):0] fifo_count;
  logic busy;
  logic overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ACCW-1:0] exp_q[$];

  rv_conv_accumulator_if #(.DATAW(DATAW), .ACCW(ACCW), .CNTW(CNTW)) bus ();

  rv_conv_accumulator #(.DATAW(DATAW), .ACCW(ACCW), .CNTW(CNTW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference accumulation step
  function automatic logic [ACCW-1:0] model_step(input logic [ACCW-1:0] a, input logic [DATAW-1:0] d);
    int s;
    s = int'($signed(a)) + int'($signed(d));
`ifdef RV_ACC_SAT_EN
    if (s > (1 << (ACCW - 1)) - 1) s = (1 << (ACCW - 1)) - 1;
    if (s < -(1 << (ACCW - 1))) s = -(1 << (ACCW - 1));
`endif
    return ACCW'(s);
  endfunction

  // driver tasks
  task automatic send(input logic [DATAW-1:0] d, input logic [CNTW-1:0] terms);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.cfg_terms = terms;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_group(input logic [CNTW-1:0] terms, input logic [DATAW-1:0] d[$]);
    logic [ACCW-1:0] a;
    a = '0;
    foreach (d[i]) begin
      a = model_step(a, d[i]);
      send(d[i], terms);
    end
    exp_q.push_back(a);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: compare every accepted output beat against the expected queue
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(bus.out_data), 32'hffff_ffff);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [CNTW-1:0]  r_terms;
    logic [DATAW-1:0] r_data[$];
    int               n_terms;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_terms = 8'd1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // 1: basic group of three
    bus.out_ready = 1'b1;
    exp_q.push_back(10'd10);
    send(8'd5, 8'd3);
    check("t1_busy0", busy, 1);
    send(8'hFE, 8'd3);
    check("t1_busy1", busy, 1);
    check("t1_no_valid_yet", bus.out_valid, 0);
    send(8'd7, 8'd3);
    check("t1_busy2", busy, 0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", 32'(bus.out_data), 10);
    wait_drain("t1_drain");
    check("t1_empty_after_pop", 32'(fifo_count), 0);

    // 2: gaps inside a group, mid-group cfg change ignored
    exp_q.push_back(10'd6);
    send(8'd1, 8'd3);
    idle(1);
    send(8'd2, 8'd7);
    idle(2);
    check("t2_busy_mid", busy, 1);
    send(8'd3, 8'd7);
    check("t2_busy_end", busy, 0);
    check("t2_data", 32'(bus.out_data), 6);
    wait_drain("t2_drain");

    // 3: fill, overflow, full push+pop
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(ACCW'(i));
      send(DATAW'(i), 8'd1);
    end
    check("t3_count_full", 32'(fifo_count), 4);
    check("t3_overflow", overflow, 1);
    check("t3_head", 32'(bus.out_data), 1);
    bus.out_ready = 1'b1;
    exp_q.push_back(10'd6);
    send(8'd6, 8'd0);
    check("t3_count_pushpop", 32'(fifo_count), 4);
    check("t3_overflow_sticky", overflow, 1);
    wait_drain("t3_drain");

    // 4: clear aborts the group, drops the same-cycle input, leaves FIFO alone
    bus.out_ready = 1'b0;
    exp_q.push_back(10'd42);
    send(8'd42, 8'd1);
    send(8'd10, 8'd4);
    send(8'd20, 8'd4);
    check("t4_busy_before_clear", busy, 1);
    bus.clear = 1'b1;
    send(8'd99, 8'd4);
    bus.clear = 1'b0;
    check("t4_busy_after_clear", busy, 0);
    check("t4_count_after_clear", 32'(fifo_count), 1);
    send_group(8'd4, '{8'd1, 8'd1, 8'd1, 8'd1});
    check("t4_count_after_group", 32'(fifo_count), 2);
    bus.out_ready = 1'b1;
    wait_drain("t4_drain");

    // 5: wrap or saturate
`ifdef RV_ACC_SAT_EN
    exp_q.push_back(10'd511);
`else
    exp_q.push_back(10'h3F8);
`endif
    for (int i = 0; i < 8; i++) send(8'd127, 8'd8);
`ifdef RV_ACC_SAT_EN
    check("t5_sat", 32'(bus.out_data), 511);
`else
    check("t5_wrap", 32'(bus.out_data), 32'h3F8);
`endif
    wait_drain("t5_drain");

    // random groups, cfg_terms 0 counts as 1
    for (int g = 0; g < 12; g++) begin
      r_terms = CNTW'($urandom_range(0, 5));
      n_terms = (r_terms == 0) ? 1 : int'(r_terms);
      r_data.delete();
      for (int i = 0; i < n_terms; i++) r_data.push_back(DATAW'($urandom_range(0, 255)));
      send_group(r_terms, r_data);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    wait_drain("rand_drain");

    // 6: reset mid-group with results queued
    bus.out_ready = 1'b0;
    send(8'd7, 8'd1);
    send(8'd8, 8'd1);
    send(8'd1, 8'd3);
    send(8'd2, 8'd3);
    check("t6_count_pre", 32'(fifo_count), 2);
    check("t6_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_count", 32'(fifo_count), 0);
    check("t6_busy", busy, 0);
    check("t6_overflow", overflow, 0);
    check("t6_out_data", 32'(bus.out_data), 0);
    check("t6_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send_group(8'd3, '{8'd4, 8'd4, 8'd4});
    check("t6_data", 32'(bus.out_data), 12);
    wait_drain("t6_drain");

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rv_conv_accumulator.md
Name: rv_conv_accumulator

Overview:
Downstream consumer of the conv-unit adder tree. Accumulates a configurable number of consecutive adder-tree sums (partial dot products across channels or kernel rows) into one signed result per output pixel. Buffers completed results in a small first-word-fall-through FIFO for the writeback side, with a ready/valid output handshake. The adder tree has no backpressure, so FIFO overflow drops results and raises a sticky flag.

Parameters:
DATAW, 8, width of incoming adder-tree sum; two's complement signed
ACCW, 16, accumulator/result width; must be >= DATAW
CNTW, 8, width of the term-count configuration
DEPTH, 4, output FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  adder-tree active; in_data valid this cycle
in_data  input  DATAW  adder-tree dout; signed
cfg_terms  input  CNTW  sums per result; 0 treated as 1
clear  input  1  abort the current group; discard partial sum
out_valid  output  1  FIFO non-empty
out_data  output  ACCW  FIFO head; valid when out_valid
out_ready  input  1  consumer accepts head
fifo_count  output  $clog2(DEPTH)+1  occupied entries
busy  output  1  a group is in progress (term count != 0)
overflow  output  1  sticky: a completed result was dropped

Behaviour:
- Reset: acc=0, term count=0, latched terms=1, FIFO empty. out_valid=0, out_data=0, fifo_count=0, busy=0, overflow=0. Reset mid-group discards the partial sum and all FIFO contents.
- Group start: in_valid with count==0 latches cfg_terms (0->1) as T. cfg_terms changes mid-group are ignored.
- Each in_valid: addend = in_data sign-extended to ACCW. First term: acc <= addend. Otherwise acc <= acc + addend, with ACCW wrap (see optional feature). count increments.
- Last term (count==T-1, including T==1): sum = acc+addend (or addend if T==1) is pushed to the FIFO. count<=0 and acc<=0. out_valid rises the next cycle: 1-cycle latency from the last input.
- Cycles with in_valid=0 hold acc and count. Gaps within a group are legal.
- clear: count<=0, acc<=0. FIFO and overflow unaffected. If clear and in_valid occur together, clear wins and the input is dropped.
- FIFO: FWFT. out_data shows the head combinationally from storage and is 0 when empty. Pop on out_valid && out_ready. out_ready with an empty FIFO is a no-op.
- Push and pop in the same cycle: both occur, and fifo_count is unchanged. This holds when full; no drop in that case.
- Push when full with no pop: the result is dropped, FIFO unchanged, overflow<=1. overflow clears only on reset.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- busy = (count != 0).

Optional Feature:
Macro RV_ACC_SAT_EN.
- Defined: every accumulation step saturates to the signed ACCW range [-2^(ACCW-1), 2^(ACCW-1)-1]. Saturation is sticky within a group: later terms add to the clamped value.
- Undefined: two's-complement wrap modulo 2^ACCW.
- Ports are identical in both builds.

Test Plan:
1. cfg_terms=3; in_data 5, -2 (0xFE), 7 on consecutive cycles; out_ready=1 -> out_valid=1 with out_data=10 one cycle after the third input; busy 1,1,0; one pop.
2. cfg_terms=3; inputs 1, idle, 2, idle, idle, 3; cfg_terms changed to 7 after the first input -> single result 6; the change is ignored.
3. out_ready=0; cfg_terms=1; inputs 1..5 -> fifo_count=4, overflow=1 after the 5th input. Then out_ready=1 pops 1,2,3,4, and 5 is lost. With FIFO full, a push and pop in the same cycle keeps fifo_count=4 with no drop.
4. cfg_terms=4; inputs 10, 20; clear asserted together with an in_valid of 99; then 1,1,1,1 -> single result 4; 99 is dropped; the FIFO is untouched by clear.
5. ACCW=10; cfg_terms=8; eight inputs of 127 -> with RV_ACC_SAT_EN: 511. Without: 1016 mod 1024 signed = -8 (0x3F8).
6. reset asserted after 2 of 3 terms with 2 results queued -> next cycle fifo_count=0, busy=0, overflow=0, out_data=0. Fresh group 4,4,4 -> 12.
